branch_unit: RTL and testbench

Parametrised, multicycle branch resolution unit for the OTTER multicycle core. It accepts a branch request (operands, func3, PC, immediate) over a valid/ready handshake and compares the operands iteratively, CHUNK bits per cycle from the MSB down, exiting early once the outcome is decided. It returns the taken decision and the branch target over a second valid/ready handshake. It sits between register-file read and the PC-select logic, replacing the single-cycle comparator where XLEN grows or area matters.

---
 rtl/branch_unit.sv | 145 ++++++++++++++
 tb/tb_branch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// Multicycle branch resolution unit: compares operands CHUNK bits per cycle, MSB first, with early exit.
// Optional define BRANCH_UNIT_MISALIGN_EN builds the taken-target misalignment check.
module branch_unit #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            take_branch,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NCHUNK - 1);
  localparam logic [XLEN-1:0]  SIGN_BIT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   rs1_q;
  logic [XLEN-1:0]   rs2_q;
  logic [2:0]        func3_q;
  logic [IDX_W-1:0]  idx;
  logic [XLEN-1:0]   target_q;
  logic              take_q;
  logic              accept;
  logic              req_signed;

  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic              chunk_ne;
  logic              chunk_lt;
  logic              last_chunk;
  logic              invalid_op;
  logic              decided;
  logic              take_next;

  function automatic logic resolve(input logic [2:0] f, input logic eq, input logic lt);
    logic r;
    case (f)
      3'b000:         r = eq;
      3'b001:         r = !eq;
      3'b100, 3'b110: r = lt;
      3'b101, 3'b111: r = !lt;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

  assign req_ready   = (state == IDLE) && !rst;
  assign resp_valid  = (state == DONE);
  assign accept      = req_valid && req_ready;
  assign take_branch = take_q;
  assign target      = target_q;
  assign req_signed  = (func3[2:1] == 2'b10);

  // Operands shift left each cycle, so the chunk under test is always the top one.
  always_comb begin
    a_chunk    = rs1_q[XLEN-1 -: CHUNK];
    b_chunk    = rs2_q[XLEN-1 -: CHUNK];
    chunk_ne   = (a_chunk != b_chunk);
    chunk_lt   = (a_chunk < b_chunk);
    last_chunk = (idx == '0);
    invalid_op = (func3_q[2:1] == 2'b01);
    decided    = invalid_op || chunk_ne || last_chunk;
    take_next  = resolve(func3_q, !chunk_ne, chunk_ne && chunk_lt);
  end

  // NOTE: operand/func3 registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      // Flipping the sign bit turns a signed compare into an unsigned one.
      rs1_q   <= rs1 ^ (req_signed ? SIGN_BIT : '0);
      rs2_q   <= rs2 ^ (req_signed ? SIGN_BIT : '0);
      func3_q <= func3;
    end else if (state == CMP && !decided) begin
      rs1_q <= rs1_q << CHUNK;
      rs2_q <= rs2_q << CHUNK;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      target_q <= '0;
      take_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            target_q <= pc + imm;
            idx      <= IDX_TOP;
            state    <= CMP;
          end
        end
        CMP: begin
          if (decided) begin
            take_q <= take_next;
            state  <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRANCH_UNIT_MISALIGN_EN
  logic mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (state == CMP && decided) begin
      mis_q <= take_next && (target_q[1:0] != 2'b00);
    end
  end

  assign misaligned = mis_q;
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: directed cases plus randomized requests against a behavioural model.
module tb_branch_unit;
  localparam int XLEN   = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = XLEN / CHUNK;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [XLEN-1:0]  rs1 = '0, rs2 = '0, pc = '0, imm = '0;
  logic [2:0]       func3 = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic             take_branch;
  logic [XLEN-1:0]  target;
  logic             misaligned;

  branch_unit #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .rs1(rs1), .rs2(rs2), .func3(func3), .pc(pc), .imm(imm),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .take_branch(take_branch), .target(target), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        take;
    logic [31:0] target;
    logic        mis;
    int          lat;
    int          acc;
    bit          hold5;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                                 input logic [31:0] p, input logic [31:0] i, input int acc,
                                 input bit hold5);
    exp_t        e;
    logic [31:0] x;
    int          top;
    e.target = p + i;
    e.acc    = acc;
    e.hold5  = hold5;
    case (f)
      3'b000:  e.take = (a == b);
      3'b001:  e.take = (a != b);
      3'b100:  e.take = ($signed(a) <  $signed(b));
      3'b101:  e.take = ($signed(a) >= $signed(b));
      3'b110:  e.take = (a <  b);
      3'b111:  e.take = (a >= b);
      default: e.take = 1'b0;
    endcase
    if (f == 3'b010 || f == 3'b011) begin
      e.lat = 1;
    end else begin
      x = a ^ b;
      if (x == 0) begin
        e.lat = NCHUNK;
      end else begin
        top = 0;
        for (int n = 0; n < 32; n++) if (x[n]) top = n;
        e.lat = (31 - top) / CHUNK + 1;
      end
    end
`ifdef BRANCH_UNIT_MISALIGN_EN
    e.mis = e.take && (e.target[1:0] != 2'b00);
`else
    e.mis = 1'b0;
`endif
    return e;
  endfunction

  // Monitor: checks latency on arrival, stability while stalled, and values on handshake.
  bit          prev_valid = 0;
  int          hold = 0;
  exp_t        cur;
  logic        snap_take, snap_mis;
  logic [31:0] snap_tgt;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 0;
      resp_ready = 1'b0;
    end else begin
      if (resp_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 32'(resp_valid), 32'd0);
          hold = 0;
        end else begin
          cur = sb[0];
          check("latency", cyc - cur.acc, cur.lat);
          hold = cur.hold5 ? 5 : int'($urandom_range(0, 2));
        end
        snap_take = take_branch;
        snap_tgt  = target;
        snap_mis  = misaligned;
      end else if (resp_valid) begin
        check("stall_take", 32'(take_branch), 32'(snap_take));
        check("stall_target", target, snap_tgt);
        check("stall_mis", 32'(misaligned), 32'(snap_mis));
        check("stall_req_ready", 32'(req_ready), 32'd0);
      end
      if (resp_valid) begin
        if (hold == 0) begin
          if (sb.size() > 0) begin
            cur = sb.pop_front();
            check("take_branch", 32'(take_branch), 32'(cur.take));
            check("target", target, cur.target);
            check("misaligned", 32'(misaligned), 32'(cur.mis));
          end
          resp_ready = 1'b1;
        end else begin
          resp_ready = 1'b0;
          hold--;
        end
      end else begin
        resp_ready = 1'b0;
      end
      prev_valid = resp_valid;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                       input logic [31:0] p, input logic [31:0] i, input bit hold5);
    int guard;
    @(negedge clk);
    rs1 = a; rs2 = b; func3 = f; pc = p; imm = i;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 32'(req_ready), 32'd1);
    end else begin
      @(posedge clk);
      #1;
      sb.push_back(model(a, b, f, p, i, cyc, hold5));
    end
    req_valid = 1'b0;
    // Scramble request inputs: they must only matter at the accept edge.
    rs1 = $urandom; rs2 = $urandom; func3 = 3'($urandom_range(0, 7));
    pc = $urandom; imm = $urandom;
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && !resp_valid && req_ready) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", 32'(sb.size() == 0 && !resp_valid && req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, b;
    logic [2:0]  f;

    #2;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_take", 32'(take_branch), 32'd0);
    check("rst_target", target, 32'd0);
    check("rst_mis", 32'(misaligned), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("post_rst_req_ready", 32'(req_ready), 32'd1);

    issue(32'h12345678, 32'h12345678, 3'b000, 32'h0000_1000, 32'h0000_0040, 0);
    issue(32'h12345678, 32'h12345678, 3'b001, 32'h0000_1000, 32'h0000_0040, 0);
    issue(32'hFFFFFFFF, 32'h00000001, 3'b100, 32'h0000_2000, 32'hFFFF_FFF0, 0);
    issue(32'hFFFFFFFF, 32'h00000001, 3'b110, 32'h0000_2000, 32'hFFFF_FFF0, 0);
    issue(32'h00000010, 32'h00000011, 3'b101, 32'h0000_3000, 32'h0000_0008, 0);
    issue(32'h80000000, 32'h7FFFFFFF, 3'b111, 32'h0000_3000, 32'h0000_0008, 0);
    issue(32'hDEADBEEF, 32'h01234567, 3'b010, 32'hFFFF_FFF0, 32'h0000_0020, 0);
    issue(32'hCAFEF00D, 32'hCAFEF00D, 3'b000, 32'h0000_4000, 32'h0000_0100, 1);
    issue(32'h00000055, 32'h00000055, 3'b000, 32'h0000_0100, 32'h0000_0002, 0);
    issue(32'h00000055, 32'h00000055, 3'b001, 32'h0000_0100, 32'h0000_0002, 0);
    wait_idle();

    // Reset mid-compare discards the in-flight request.
    @(negedge clk);
    rs1 = 32'hA5A5A5A5; rs2 = 32'hA5A5A5A5; func3 = 3'b000;
    pc = 32'h0000_0200; imm = 32'h0000_0010;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midcmp_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("midcmp_rst_req_ready", 32'(req_ready), 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("after_rst_req_ready", 32'(req_ready), 32'd1);
    check("after_rst_resp_valid", 32'(resp_valid), 32'd0);
    issue(32'h00000007, 32'h00000009, 3'b110, 32'h0000_0300, 32'h0000_0004, 0);

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (32'd1 << $urandom_range(0, 31));
        2:       b = $urandom;
        default: b = a + 32'd1;
      endcase
      f = 3'($urandom_range(0, 7));
      issue(a, b, f, $urandom, $urandom, 0);
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
